// File: rtl/popcount_sched.sv
// Two-requester popcount scheduler: one shared count_ones unit, round-robin
// job arbitration, saturating accumulator, result held until consumed.

// Combinational 8-bit population count.
module count_ones (
  input  logic [7:0] data,
  output logic [3:0] count
);

  // Sum the individual bits of the input byte.
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, data[i]};
    end
  end

endmodule

module popcount_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

  state_t           state_reg, state_next;
  logic             grant_reg;
  logic             last_grant_reg;
  logic [CNT_W-1:0] acc_reg;

  logic             sel_valid;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic             accept;
  logic             arb_grant;
  logic             any_valid;
  logic             res_done;
  logic [3:0]       beat_count;
  logic [CNT_W:0]   sum_wide;
  logic [CNT_W-1:0] acc_sum;

  // Only the granted port's beat reaches the shared counter.
  assign sel_valid = grant_reg ? req1_valid : req0_valid;
  assign sel_data  = grant_reg ? req1_data  : req0_data;
  assign sel_last  = grant_reg ? req1_last  : req0_last;
  assign accept    = (state_reg == RUN) && sel_valid;
  assign any_valid = req0_valid || req1_valid;
  assign res_done  = (state_reg == RESULT) && res_ready;

  // When both want the unit, the port that did not win last time goes first.
  assign arb_grant = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;

  count_ones u_count_ones (
    .data  (sel_data),
    .count (beat_count)
  );

  // One extra bit catches overflow so the accumulator clamps at all-ones.
  assign sum_wide = {1'b0, acc_reg} + {{(CNT_W-3){1'b0}}, beat_count};
  assign acc_sum  = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid)           state_next = RUN;
      RUN:     if (accept && sel_last)  state_next = RESULT;
      RESULT:  if (res_ready)           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Grant, round-robin history and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      acc_reg        <= '0;
    end else begin
      if ((state_reg == IDLE) && any_valid) grant_reg <= arb_grant;
      if (accept) acc_reg <= acc_sum;
      if (res_done) begin
        acc_reg        <= '0;
        last_grant_reg <= grant_reg;
      end
    end
  end

  // Outputs decoded from state; result fields read zero outside RESULT.
  always_comb begin
    req0_ready = (state_reg == RUN) && !grant_reg;
    req1_ready = (state_reg == RUN) &&  grant_reg;
    res_valid  = (state_reg == RESULT);
    res_data   = (state_reg == RESULT) ? acc_reg : '0;
    res_id     = (state_reg == RESULT) && grant_reg;
    busy       = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched: an 8-bit and a 4-bit accumulator
// instance see identical stimulus; expected jobs go into a scoreboard queue
// and are popped when a result handshake is about to complete.
module tb_popcount_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_last, req1_valid, req1_last, res_ready;
  logic [7:0] req0_data, req1_data;

  logic       req0_ready, req1_ready, res_valid, res_id, busy;
  logic [7:0] res_data;
  logic       d4_req0_ready, d4_req1_ready, d4_res_valid, d4_res_id, d4_busy;
  logic [3:0] d4_res_data;

  popcount_sched #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  popcount_sched #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(d4_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(d4_req1_ready),
    .res_valid(d4_res_valid), .res_ready(res_ready), .res_data(d4_res_data), .res_id(d4_res_id), .busy(d4_busy)
  );

  typedef struct {
    int   sum;
    logic id;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare any result handshake that the coming edge will complete, then
  // advance one clock and settle just past the edge.
  task automatic cycle();
    exp_t e;
    if (res_valid && res_ready && !rst) begin
      check("result_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("res_data", 32'(res_data), 32'((e.sum > 255) ? 255 : e.sum));
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_data_w4", 32'(d4_res_data), 32'((e.sum > 15) ? 15 : e.sum));
        check("res_valid_w4", 32'(d4_res_valid), 32'd1);
        $display("result id=%0d data=%0d data_w4=%0d", res_id, res_data, d4_res_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic port, input logic [7:0] data, input logic last);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_data = data; req1_last = last;
    end else begin
      req0_valid = 1'b1; req0_data = data; req0_last = last;
    end
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      cycle();
      n++;
    end
    check("beat_ready", 32'(port ? req1_ready : req0_ready), 32'd1);
    cycle();
    $display("beat port=%0d data=%02h last=%0d", port, data, last);
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    res_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_ready0"},    32'(req0_ready), 32'd0);
    check({tag, "_ready1"},    32'(req1_ready), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_res_data"},  32'(res_data), 32'd0);
    check({tag, "_res_id"},    32'(res_id), 32'd0);
    check({tag, "_busy_w4"},   32'(d4_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_last = 1'b0;  req1_last = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    res_ready = 1'b0;
    cycle();
    cycle();
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    // Single-beat job from req0, one-cycle result latency.
    do_reset();
    q.push_back('{sum: 5, id: 1'b0});
    drive_beat(1'b0, 8'b0101_0111, 1'b1);
    check("latency_res_valid", 32'(res_valid), 32'd1);
    check("latency_busy", 32'(busy), 32'd1);
    drain();

    // Three-beat job from req1 with an idle gap, then the result is held.
    q.push_back('{sum: 16, id: 1'b1});
    drive_beat(1'b1, 8'hCC, 1'b0);
    cycle();
    drive_beat(1'b1, 8'h33, 1'b0);
    cycle();
    drive_beat(1'b1, 8'hFF, 1'b1);
    req0_valid = 1'b1; req0_data = 8'hFF; req0_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", 32'(res_data), 32'd16);
      check("hold_res_id", 32'(res_id), 32'd1);
      check("hold_ready0", 32'(req0_ready), 32'd0);
      check("hold_ready1", 32'(req1_ready), 32'd0);
      cycle();
    end
    req0_valid = 1'b0;
    drain();

    // Both requesters valid continuously: grants alternate starting at 0.
    do_reset();
    q.push_back('{sum: 8, id: 1'b0});
    q.push_back('{sum: 0, id: 1'b1});
    q.push_back('{sum: 8, id: 1'b0});
    q.push_back('{sum: 0, id: 1'b1});
    req0_valid = 1'b1; req0_data = 8'hFF; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h00; req1_last = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("rr_single_ready", 32'(req0_ready && req1_ready), 32'd0);
      cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b0;
    check("rr_all_results", 32'(q.size()), 32'd0);

    // Saturation: 20 set bits clamp to 15 in the 4-bit instance.
    q.push_back('{sum: 20, id: 1'b0});
    drive_beat(1'b0, 8'hFF, 1'b0);
    drive_beat(1'b0, 8'hFF, 1'b0);
    drive_beat(1'b0, 8'h0F, 1'b1);
    check("sat_w4_data", 32'(d4_res_data), 32'd15);
    drain();

    // Reset in the middle of a job discards it.
    drive_beat(1'b0, 8'hFF, 1'b0);
    drive_beat(1'b0, 8'hFF, 1'b0);
    rst = 1'b1;
    res_ready = 1'b1;
    cycle();
    check_reset_outputs("midjob_reset");
    rst = 1'b0;
    res_ready = 1'b0;
    cycle();
    check("midjob_no_result", 32'(res_valid), 32'd0);
    q.push_back('{sum: 0, id: 1'b0});
    drive_beat(1'b0, 8'h00, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/popcount_sched.md
POPCOUNT_SCHED -- requirements
Module: popcount_sched

Interface
REQ-001 SHALL have parameter: CNT_W, 8, accumulator and result width in bits (legal range 4..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester N presents a data beat.
REQ-005 SHALL have ports: req0_data / req1_data  input  8  byte whose set bits are counted.
REQ-006 SHALL have ports: req0_last / req1_last  input  1  beat is final beat of the job.
REQ-007 SHALL have ports: req0_ready / req1_ready  output  1  beat accepted when valid&&ready.
REQ-008 SHALL have port: res_valid  output  1  job result available.
REQ-009 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: res_data  output  CNT_W  total set bits over the job.
REQ-011 SHALL have port: res_id  output  1  requester that owned the job.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL share one instance of the existing count_ones unit (8-bit in, 4-bit out) between both requesters; no second counter.
REQ-014 SHALL implement FSM states IDLE, RUN, RESULT.
REQ-015 IDLE: if any reqN_valid, SHALL latch grant and go to RUN on the next edge; no beat is accepted in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both valid, grant the port not equal to last_grant; if one valid, grant it.
REQ-017 last_grant SHALL update to the granted port when the result handshake completes.
REQ-018 reqN_ready SHALL be high only in RUN for the granted port, and low otherwise; the non-granted port is stalled.
REQ-019 Each accepted beat SHALL add count_ones(data) to the accumulator on that edge.
REQ-020 Accumulator SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 An accepted beat with last=1 SHALL move the FSM to RUN->RESULT; res_valid SHALL be high the cycle after that beat (1-cycle latency).
REQ-022 In RUN, cycles with valid low SHALL leave the accumulator unchanged and the FSM in RUN.
REQ-023 RESULT: res_valid=1, res_data=accumulator, res_id=grant, all stable until res_ready=1.
REQ-024 On res_valid&&res_ready SHALL clear accumulator, go to IDLE; a new grant is earliest the following cycle.
REQ-025 Valid deassertion by a non-granted requester SHALL have no effect on the active job.

Reset
REQ-026 On rst=1 at an edge SHALL set state=IDLE, accumulator=0, last_grant=1, grant=0.
REQ-027 During/after reset SHALL drive res_valid=0, req0_ready=0, req1_ready=0, busy=0, res_data=0, res_id=0.
REQ-028 Reset mid-job SHALL discard the partial job; no result is produced for it.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-030 After reset, req0 one beat 8'b01010111 last=1 -> res_valid next cycle, res_data=5, res_id=0.
REQ-031 req1 beats 8'hCC, 8'h33, 8'hFF (last on third), with one idle valid=0 cycle between -> res_data=16, res_id=1.
REQ-032 After reset, both requesters valid continuously, single-beat jobs 8'hFF and 8'h00 -> res_id order 0,1,0,1; res_data 8,0,8,0.
REQ-033 CNT_W=4: req0 beats 8'hFF, 8'hFF, 8'h0F last -> res_data=15 (saturated), not wrapped.
REQ-034 Result ready held low 5 cycles -> res_valid, res_data, res_id constant; both reqN_ready=0 throughout.
REQ-035 rst pulsed after 2 accepted beats of a req0 job -> all outputs reset values next cycle; subsequent job 8'h00 last -> res_data=0.
